// File: rtl/astable_555_pkg.sv
// Shared constants, channel state encoding and the fixed low-time calculation
// for the multi-channel 555 astable VCO.
package astable_555_pkg;

  localparam int unsigned Ln2Q16 = 45426;
  localparam int unsigned Vcc    = 65535;
  localparam int unsigned VcMax  = 65531;

  typedef enum logic [1:0] {
    StResetHold,
    StHigh,
    StLow
  } ch_state_e;

  // Discharge phase length in clk cycles; only R2 is in the discharge path.
  function automatic logic [31:0] calc_cycles_low(input logic [63:0] c35,
                                                  input logic [63:0] r2,
                                                  input logic [63:0] clk_rate);
    logic [63:0] t;
    t = (c35 * r2 * 64'(Ln2Q16)) >> 29;
    t = (t * clk_rate) >> 22;
    return (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
  endfunction

endpackage

// File: rtl/natural_log.sv
// Combinational natural log of a Q8 value, Q8 result: octave from the leading
// one plus a 16-segment interpolated table for the mantissa.
module natural_log
  import astable_555_pkg::*;
(
  input  logic [23:0] x_i,
  output logic [11:0] ln_o
);

  // ln(1 + i/16) in Q16.
  function automatic logic [15:0] ln_tab(input logic [4:0] i);
    unique case (i)
      5'd0:    return 16'd0;
      5'd1:    return 16'd3973;
      5'd2:    return 16'd7719;
      5'd3:    return 16'd11262;
      5'd4:    return 16'd14624;
      5'd5:    return 16'd17822;
      5'd6:    return 16'd20870;
      5'd7:    return 16'd23783;
      5'd8:    return 16'd26573;
      5'd9:    return 16'd29248;
      5'd10:   return 16'd31818;
      5'd11:   return 16'd34292;
      5'd12:   return 16'd36675;
      5'd13:   return 16'd38975;
      5'd14:   return 16'd41197;
      5'd15:   return 16'd43345;
      default: return 16'd45426;
    endcase
  endfunction

  logic [4:0]  msb;
  logic [23:0] norm;
  logic [15:0] t0, t1;
  logic [23:0] interp;
  logic [31:0] total;
  logic        unused_norm;

  always_comb begin
    msb = '0;
    for (int b = 0; b < 24; b++) begin
      if (x_i[b]) msb = 5'(b);
    end
    norm   = x_i << (5'd23 - msb);
    t0     = ln_tab({1'b0, norm[22:19]});
    t1     = ln_tab({1'b0, norm[22:19]} + 5'd1);
    interp = 24'(t0) + ((24'(t1 - t0) * 24'(norm[18:11])) >> 8);
    total  = 32'(msb - 5'd8) * 32'(Ln2Q16) + 32'(interp) + 32'd128;
    ln_o   = '0;
    // Inputs below 1.0 would give a negative log; the VCO ratio never goes there.
    if (msb >= 5'd8) begin
      ln_o = ((total >> 8) > 32'd4095) ? 12'hFFF : 12'(total >> 8);
    end
  end

  assign unused_norm = ^{norm[23], norm[10:0]};

endmodule

// File: rtl/vco_period_calc.sv
// Time-multiplexed high-time calculator: one channel enters the 3-stage
// pipeline per clk and its high length is emitted as a table write.
module vco_period_calc
  import astable_555_pkg::*;
#(
  parameter int unsigned CLOCK_RATE   = 50000000,
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned R1           = 47000,
  parameter int unsigned R2           = 27000,
  parameter int unsigned C_35_SHIFTED = 1134,
  parameter int unsigned IdxW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [16*CHANNELS-1:0] v_control_i,
  output logic                   wr_o,
  output logic [IdxW-1:0]        wr_ch_o,
  output logic [31:0]            high_len_o
);

  localparam logic [63:0] KTime = 64'(C_35_SHIFTED) * 64'(R1 + R2) * 64'(CLOCK_RATE);

  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] s1_ch_q, s1_ch_d, s2_ch_q, s2_ch_d;
  logic            s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [23:0]     s1_ratio_q, s1_ratio_d;
  logic [11:0]     s2_ln_q, s2_ln_d;
  logic [11:0]     ln_w;
  logic [15:0]     vc_raw, vc;
  logic [17:0]     den;
  logic [63:0]     prod, hl_full;

  natural_log u_ln (
    .x_i  (s1_ratio_q),
    .ln_o (ln_w)
  );

  always_comb begin
    idx_d      = (idx_q == IdxW'(CHANNELS - 1)) ? '0 : idx_q + 1'b1;
    vc_raw     = v_control_i[{idx_q, 4'b0000} +: 16];
    vc         = (vc_raw > 16'(VcMax)) ? 16'(VcMax) : vc_raw;
    den        = {17'(Vcc) - 17'(vc), 1'b0};
    s1_ratio_d = 24'd256 + ({vc, 8'b0} / 24'(den));
    s1_ch_d    = idx_q;
    s1_vld_d   = 1'b1;
    s2_ln_d    = ln_w;
    s2_ch_d    = s1_ch_q;
    s2_vld_d   = s1_vld_q;
    prod       = KTime * 64'(s2_ln_q);
    hl_full    = prod >> 43;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= '0;
      s1_ch_q    <= '0;
      s1_vld_q   <= 1'b0;
      s1_ratio_q <= 24'd256;
      s2_ch_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_ln_q    <= '0;
    end else begin
      idx_q      <= idx_d;
      s1_ch_q    <= s1_ch_d;
      s1_vld_q   <= s1_vld_d;
      s1_ratio_q <= s1_ratio_d;
      s2_ch_q    <= s2_ch_d;
      s2_vld_q   <= s2_vld_d;
      s2_ln_q    <= s2_ln_d;
    end
  end

  assign wr_o       = s2_vld_q;
  assign wr_ch_o    = s2_ch_q;
  assign high_len_o = (hl_full > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : hl_full[31:0];

endmodule

// File: rtl/astable_555_vco_multi.sv
// Multi-channel 555 astable VCO: high-length table, per-channel phase FSMs and
// audio-rate output sample registers.
module astable_555_vco_multi
  import astable_555_pkg::*;
#(
  parameter int unsigned CLOCK_RATE   = 50000000,
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned R1           = 47000,
  parameter int unsigned R2           = 27000,
  parameter int unsigned C_35_SHIFTED = 1134,
  parameter logic [15:0] AMPLITUDE    = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   audio_clk_en,
  input  logic [16*CHANNELS-1:0] v_control,
  input  logic [CHANNELS-1:0]    reset_555_n,
  output logic [16*CHANNELS-1:0] out
);

  localparam int unsigned IdxW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [31:0] CyclesLow = calc_cycles_low(64'(C_35_SHIFTED), 64'(R2),
                                                      64'(CLOCK_RATE));

  logic                   wr;
  logic [IdxW-1:0]        wr_ch;
  logic [31:0]            wr_len;

  ch_state_e              state_q    [CHANNELS];
  ch_state_e              state_d    [CHANNELS];
  logic [31:0]            cnt_q      [CHANNELS];
  logic [31:0]            cnt_d      [CHANNELS];
  logic [31:0]            cur_high_q [CHANNELS];
  logic [31:0]            cur_high_d [CHANNELS];
  logic [31:0]            high_len_q [CHANNELS];
  logic [31:0]            high_len_d [CHANNELS];
  logic [16*CHANNELS-1:0] out_q, out_d;

  vco_period_calc #(
    .CLOCK_RATE   (CLOCK_RATE),
    .CHANNELS     (CHANNELS),
    .R1           (R1),
    .R2           (R2),
    .C_35_SHIFTED (C_35_SHIFTED),
    .IdxW         (IdxW)
  ) u_calc (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .v_control_i (v_control),
    .wr_o        (wr),
    .wr_ch_o     (wr_ch),
    .high_len_o  (wr_len)
  );

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      high_len_d[k] = high_len_q[k];
      state_d[k]    = state_q[k];
      cnt_d[k]      = cnt_q[k];
      cur_high_d[k] = cur_high_q[k];
    end
    if (wr) high_len_d[wr_ch] = wr_len;

    // Latches read high_len_q, so a same-cycle table write is seen next period.
    for (int k = 0; k < CHANNELS; k++) begin
      if (!reset_555_n[k]) begin
        state_d[k] = StResetHold;
        cnt_d[k]   = '0;
      end else begin
        unique case (state_q[k])
          StResetHold: begin
            cnt_d[k]      = '0;
            cur_high_d[k] = high_len_q[k];
            state_d[k]    = (high_len_q[k] == '0) ? StLow : StHigh;
          end
          StHigh: begin
            if (cnt_q[k] == cur_high_q[k] - 32'd1) begin
              state_d[k] = StLow;
              cnt_d[k]   = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + 32'd1;
            end
          end
          StLow: begin
            if (cnt_q[k] == CyclesLow - 32'd1) begin
              cnt_d[k]      = '0;
              cur_high_d[k] = high_len_q[k];
              state_d[k]    = (high_len_q[k] == '0) ? StLow : StHigh;
            end else begin
              cnt_d[k] = cnt_q[k] + 32'd1;
            end
          end
          default: begin
            state_d[k] = StResetHold;
            cnt_d[k]   = '0;
          end
        endcase
      end
    end

    out_d = out_q;
    if (audio_clk_en) begin
      for (int k = 0; k < CHANNELS; k++) begin
        out_d[16*k +: 16] = (state_q[k] == StHigh) ? AMPLITUDE : 16'h0000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k]    <= StResetHold;
        cnt_q[k]      <= '0;
        cur_high_q[k] <= '0;
        high_len_q[k] <= '0;
      end
      out_q <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k]    <= state_d[k];
        cnt_q[k]      <= cnt_d[k];
        cur_high_q[k] <= cur_high_d[k];
        high_len_q[k] <= high_len_d[k];
      end
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule
